// File: rtl/dram_access_pkg.sv
// dram_access_pkg
// Shared definitions for the DRAM load/store controller.
//   DATA_WIDTH            : datapath width (fixed at 32)
//   SIZE_BYTE/HALF/WORD   : access size encodings carried on size_i
//   state_t, ST_*         : controller FSM state type and encodings
//   norm_size()           : folds the reserved size code 2'b11 onto word
package dram_access_pkg;

  localparam int DATA_WIDTH = 32;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_READ  = 2'd1;
  localparam state_t ST_WAIT  = 2'd2;
  localparam state_t ST_WRITE = 2'd3;

  // Size 2'b11 behaves exactly like a word access.
  function automatic logic [1:0] norm_size(input logic [1:0] size);
    return (size == 2'b11) ? SIZE_WORD : size;
  endfunction

endpackage

// File: rtl/dram_access_ctrl_byte_lane_align.sv
// byte_lane_align
// Purely combinational lane steering used while the controller sits in WAIT.
// Ports:
//   i_word   [31:0] word just read from DRAM
//   i_offset [1:0]  byte offset of the access (already aligned to its size)
//   i_size   [1:0]  normalised access size (byte/half/word)
//   i_sign          1 = sign-extend load result, 0 = zero-extend
//   i_wdata  [31:0] right-justified store data
//   o_load   [31:0] extracted and extended load value
//   o_merged [31:0] i_word with the addressed lane(s) replaced by store data
module byte_lane_align
  import dram_access_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_offset,
  input  logic [1:0]  i_size,
  input  logic        i_sign,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_word[{i_offset, 3'b000} +: 8];
  assign w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];

  always_comb begin
    o_load = i_word;
    case (i_size)
      SIZE_BYTE: o_load = {{24{i_sign & w_byte[7]}}, w_byte};
      SIZE_HALF: o_load = {{16{i_sign & w_half[15]}}, w_half};
      default:   o_load = i_word;
    endcase
  end

  // Each lane decides independently whether it is overwritten and which
  // byte of the right-justified store data lands in it.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic       w_hit;
      logic [7:0] w_src;

      always_comb begin
        w_hit = 1'b1;
        w_src = i_wdata[8*gi +: 8];
        case (i_size)
          SIZE_BYTE: begin
            w_hit = (i_offset == LANE);
            w_src = i_wdata[7:0];
          end
          SIZE_HALF: begin
            w_hit = (i_offset[1] == LANE[1]);
            w_src = i_wdata[8*(gi%2) +: 8];
          end
          default: begin
            w_hit = 1'b1;
            w_src = i_wdata[8*gi +: 8];
          end
        endcase
      end

      assign o_merged[8*gi +: 8] = w_hit ? w_src : i_word[8*gi +: 8];
    end
  endgenerate

endmodule

// File: rtl/dram_access_ctrl.sv
// dram_access_ctrl
// Load/store controller between the MEM stage and a word-addressed DRAM.
// Sub-word stores are done as read-modify-write; loads are returned
// lane-aligned and sign/zero extended. The MEM stage stalls on busy_o until
// the one-cycle done_o pulse.
// Optional feature macro: DRAM_ACCESS_MISALIGN_CHECK_EN
//   defined   : misaligned half/word accesses are rejected (done_o+misalign_o)
//   undefined : misalign_o is 0 and offending low address bits are cleared
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   req_i, we_i, size_i,     request (sampled only in IDLE): store/load,
//   sign_i, addr_i, wdata_i  size, extension, byte address, store data
//   rdata_o                  load result, held after done_o
//   done_o, busy_o           completion pulse / not-idle indication
//   misalign_o               qualifies done_o: access rejected
//   mem_addr_o, mem_data_o,  DRAM address (word aligned), write data,
//   mem_cs_o, mem_we_o       read strobe, write strobe
//   mem_data_i               DRAM read data (valid only at the WAIT edge)
module dram_access_ctrl
  import dram_access_pkg::*;
#(
  parameter int addr_width = 32,
  parameter int data_width = DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [1:0]            size_i,
  input  logic                  sign_i,
  input  logic [addr_width-1:0] addr_i,
  input  logic [data_width-1:0] wdata_i,
  output logic [data_width-1:0] rdata_o,
  output logic                  done_o,
  output logic                  busy_o,
  output logic                  misalign_o,
  output logic [addr_width-1:0] mem_addr_o,
  output logic [data_width-1:0] mem_data_o,
  output logic                  mem_cs_o,
  output logic                  mem_we_o,
  input  logic [data_width-1:0] mem_data_i
);

  state_t                r_state;
  logic                  r_we;
  logic [1:0]            r_size;
  logic                  r_sign;
  logic [1:0]            r_off;
  logic [data_width-1:0] r_wdata;
  logic [data_width-1:0] r_rdata;
  logic                  r_done;
  logic [addr_width-1:0] r_mem_addr;
  logic [data_width-1:0] r_mem_data;
  logic                  r_mem_cs;
  logic                  r_mem_we;

  logic [1:0]            w_size;
  logic [1:0]            w_off;
  logic                  w_reject;
  logic                  w_accept;
  logic [31:0]           w_load;
  logic [31:0]           w_merged;

  assign w_size   = norm_size(size_i);
  assign w_accept = (r_state == ST_IDLE) && req_i;

  // Offset as the access will be performed: low bits that would straddle
  // the access size are dropped. With the check enabled such requests are
  // rejected before the offset matters.
  always_comb begin
    w_off = addr_i[1:0];
    case (w_size)
      SIZE_HALF: w_off = {addr_i[1], 1'b0};
      SIZE_WORD: w_off = 2'b00;
      default:   w_off = addr_i[1:0];
    endcase
  end

`ifdef DRAM_ACCESS_MISALIGN_CHECK_EN
  logic w_misalign;
  logic r_misalign;

  assign w_misalign = ((w_size == SIZE_HALF) && addr_i[0]) ||
                      ((w_size == SIZE_WORD) && (addr_i[1:0] != 2'b00));
  assign w_reject   = w_misalign;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= w_accept && w_misalign;
    end
  end

  assign misalign_o = r_misalign;
`else
  assign w_reject   = 1'b0;
  assign misalign_o = 1'b0;
`endif

  byte_lane_align u_align (
    .i_word   (mem_data_i),
    .i_offset (r_off),
    .i_size   (r_size),
    .i_sign   (r_sign),
    .i_wdata  (r_wdata),
    .o_load   (w_load),
    .o_merged (w_merged)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_we       <= 1'b0;
      r_size     <= SIZE_BYTE;
      r_sign     <= 1'b0;
      r_off      <= 2'b00;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_done     <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
      r_mem_cs   <= 1'b0;
      r_mem_we   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_we       <= we_i;
            r_size     <= w_size;
            r_sign     <= sign_i;
            r_off      <= w_off;
            r_wdata    <= wdata_i;
            r_mem_addr <= {addr_i[addr_width-1:2], 2'b00};
            if (w_reject) begin
              // Rejected: complete immediately without touching DRAM.
              r_done <= 1'b1;
            end else if (we_i && (w_size == SIZE_WORD)) begin
              r_state    <= ST_WRITE;
              r_mem_we   <= 1'b1;
              r_mem_data <= wdata_i;
            end else begin
              r_state  <= ST_READ;
              r_mem_cs <= 1'b1;
            end
          end
        end
        ST_READ: begin
          r_state  <= ST_WAIT;
          r_mem_cs <= 1'b0;
        end
        ST_WAIT: begin
          // DRAM data is only valid at this edge; consume it now.
          if (r_we) begin
            r_state    <= ST_WRITE;
            r_mem_data <= w_merged;
            r_mem_we   <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
            r_rdata <= w_load;
            r_done  <= 1'b1;
          end
        end
        ST_WRITE: begin
          r_state  <= ST_IDLE;
          r_mem_we <= 1'b0;
          r_done   <= 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy_o     = (r_state != ST_IDLE);
  assign rdata_o    = r_rdata;
  assign done_o     = r_done;
  assign mem_addr_o = r_mem_addr;
  assign mem_data_o = r_mem_data;
  assign mem_cs_o   = r_mem_cs;
  assign mem_we_o   = r_mem_we;

endmodule

// File: tb/tb_dram_access_ctrl.sv
// Directed bench for dram_access_ctrl with a small synchronous DRAM model.
module tb_dram_access_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [1:0]  size_i = 2'b00;
  logic        sign_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic [31:0] rdata_o;
  logic        done_o;
  logic        busy_o;
  logic        misalign_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic        mem_cs_o;
  logic        mem_we_o;
  logic [31:0] mem_data_i;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dram_access_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req_i),
    .we_i       (we_i),
    .size_i     (size_i),
    .sign_i     (sign_i),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .rdata_o    (rdata_o),
    .done_o     (done_o),
    .busy_o     (busy_o),
    .misalign_o (misalign_o),
    .mem_addr_o (mem_addr_o),
    .mem_data_o (mem_data_o),
    .mem_cs_o   (mem_cs_o),
    .mem_we_o   (mem_we_o),
    .mem_data_i (mem_data_i)
  );

  // DRAM model: registered read on cs, write on we. Outside the cycle after
  // a cs edge it returns a junk pattern, standing in for high-Z.
  logic [31:0] dram [0:63];
  logic [31:0] dram_q = '0;
  logic        dram_v = 1'b0;

  always @(posedge clk) begin
    if (mem_we_o) dram[mem_addr_o[7:2]] <= mem_data_o;
    if (mem_cs_o) begin
      dram_q <= dram[mem_addr_o[7:2]];
      dram_v <= 1'b1;
    end else begin
      dram_v <= 1'b0;
    end
  end

  assign mem_data_i = dram_v ? dram_q : 32'hDEAD_0BAD;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request, scramble the inputs right after acceptance, then
  // watch up to 8 edges. lat = edges after the accept edge until done_o is
  // seen (0 = done already visible after the accept edge); -1 = never.
  task automatic run_req(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         output int lat, output logic [31:0] rd, output logic mis,
                         output int ncs, output int nwe);
    @(negedge clk);
    we_i = we; size_i = sz; sign_i = sg; addr_i = a; wdata_i = wd; req_i = 1'b1;
    @(posedge clk);
    #1;
    req_i = 1'b0; we_i = ~we; size_i = ~sz; sign_i = ~sg;
    addr_i = 32'h0000_00FC; wdata_i = 32'h5A5A_5A5A;
    lat = -1; rd = '0; mis = 1'b0; ncs = 0; nwe = 0;
    for (int n = 0; n < 8; n++) begin
      if (mem_cs_o) ncs++;
      if (mem_we_o) nwe++;
      check("cs_we_exclusive", {31'b0, mem_cs_o & mem_we_o}, 32'd0);
      if (done_o) begin
        lat = n; rd = rdata_o; mis = misalign_o;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int          lat;
    int          ncs;
    int          nwe;
    int          ndone;
    logic [31:0] rd;
    logic        mis;

    for (int i = 0; i < 64; i++) dram[i] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_done",   {31'b0, done_o},   32'd0);
    check("rst_busy",   {31'b0, busy_o},   32'd0);
    check("rst_strobe", {30'b0, mem_cs_o, mem_we_o}, 32'd0);
    check("rst_rdata",  rdata_o,    32'd0);
    check("rst_maddr",  mem_addr_o, 32'd0);
    check("rst_mdata",  mem_data_o, 32'd0);
    check("rst_misal",  {31'b0, misalign_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Word store then word load at 0x10
    run_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, lat, rd, mis, ncs, nwe);
    check("wst_lat", 32'(lat), 32'd1);
    check("wst_nwe", 32'(nwe), 32'd1);
    check("wst_ncs", 32'(ncs), 32'd0);
    check("wst_mem", dram[4], 32'hDEAD_BEEF);
    run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, mis, ncs, nwe);
    check("wld_lat", 32'(lat), 32'd2);
    check("wld_data", rd, 32'hDEAD_BEEF);
    check("wld_ncs", 32'(ncs), 32'd1);
    @(negedge clk);
    check("rdata_held", rdata_o, 32'hDEAD_BEEF);

    // Byte store merge at 0x21; only the low byte of wdata is used
    run_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h1122_3344, lat, rd, mis, ncs, nwe);
    check("wst2_lat", 32'(lat), 32'd1);
    run_req(1'b1, 2'b00, 1'b0, 32'h21, 32'h1234_56AA, lat, rd, mis, ncs, nwe);
    check("bst_lat", 32'(lat), 32'd3);
    check("bst_ncs", 32'(ncs), 32'd1);
    check("bst_nwe", 32'(nwe), 32'd1);
    check("bst_mem", dram[8], 32'h1122_AA44);
    run_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, lat, rd, mis, ncs, nwe);
    check("wld2_data", rd, 32'h1122_AA44);

    // Byte loads with both extensions
    run_req(1'b0, 2'b00, 1'b1, 32'h21, 32'h0, lat, rd, mis, ncs, nwe);
    check("bld_s_lat", 32'(lat), 32'd2);
    check("bld_s_data", rd, 32'hFFFF_FFAA);
    run_req(1'b0, 2'b00, 1'b0, 32'h21, 32'h0, lat, rd, mis, ncs, nwe);
    check("bld_z_data", rd, 32'h0000_00AA);

    // Halfword store to the upper half, then half and word loads
    run_req(1'b1, 2'b01, 1'b0, 32'h22, 32'hFFFF_8001, lat, rd, mis, ncs, nwe);
    check("hst_lat", 32'(lat), 32'd3);
    run_req(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, lat, rd, mis, ncs, nwe);
    check("hld_s_data", rd, 32'hFFFF_8001);
    run_req(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, lat, rd, mis, ncs, nwe);
    check("hld_z_data", rd, 32'h0000_8001);
    run_req(1'b0, 2'b01, 1'b1, 32'h20, 32'h0, lat, rd, mis, ncs, nwe);
    check("hld_lo_data", rd, 32'hFFFF_AA44);
    run_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, lat, rd, mis, ncs, nwe);
    check("wld3_data", rd, 32'h8001_AA44);
    run_req(1'b0, 2'b00, 1'b1, 32'h23, 32'h0, lat, rd, mis, ncs, nwe);
    check("bld_top_data", rd, 32'hFFFF_FF80);
    run_req(1'b0, 2'b11, 1'b1, 32'h20, 32'h0, lat, rd, mis, ncs, nwe);
    check("sz11_data", rd, 32'h8001_AA44);

    // Misaligned word load at 0x13
    run_req(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, lat, rd, mis, ncs, nwe);
`ifdef DRAM_ACCESS_MISALIGN_CHECK_EN
    check("mis_lat", 32'(lat), 32'd0);
    check("mis_flag", {31'b0, mis}, 32'd1);
    check("mis_ncs", 32'(ncs), 32'd0);
`else
    check("mis_lat", 32'(lat), 32'd2);
    check("mis_flag", {31'b0, mis}, 32'd0);
    check("mis_data", rd, 32'hDEAD_BEEF);
`endif

    // Reset during WAIT of a byte store at 0x20
    @(negedge clk);
    we_i = 1'b1; size_i = 2'b00; sign_i = 1'b0; addr_i = 32'h20; wdata_i = 32'hBB; req_i = 1'b1;
    @(posedge clk);
    #1;
    req_i = 1'b0;
    check("abort_read_cs", {31'b0, mem_cs_o}, 32'd1);
    @(posedge clk);
    #1;
    check("abort_wait_busy", {31'b0, busy_o}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", {31'b0, busy_o}, 32'd0);
    check("abort_done", {31'b0, done_o}, 32'd0);
    check("abort_strobe", {30'b0, mem_cs_o, mem_we_o}, 32'd0);
    check("abort_rdata", rdata_o, 32'd0);
    check("abort_mdata", mem_data_o, 32'd0);
    check("abort_maddr", mem_addr_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    nwe = 0;
    for (int n = 0; n < 4; n++) begin
      @(posedge clk);
      #1;
      if (done_o) ndone++;
      if (mem_we_o) nwe++;
    end
    check("abort_no_done", 32'(ndone), 32'd0);
    check("abort_no_we", 32'(nwe), 32'd0);
    check("abort_mem", dram[8], 32'h8001_AA44);
    run_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, lat, rd, mis, ncs, nwe);
    check("post_abort_lat", 32'(lat), 32'd2);
    check("post_abort_data", rd, 32'h8001_AA44);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
